// File: rtl/gate_pkg.sv
// Shared definitions for the gate models and the sweep engine.
// Holds the gate-mode encodings and the sweep FSM state type.
package gate_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] GATE_AND     = 3'b000;
    localparam logic [MODE_W-1:0] GATE_OR      = 3'b001;
    localparam logic [MODE_W-1:0] GATE_XOR     = 3'b010;
    localparam logic [MODE_W-1:0] GATE_NAND    = 3'b011;
    localparam logic [MODE_W-1:0] GATE_NOR     = 3'b100;
    localparam logic [MODE_W-1:0] GATE_XNOR    = 3'b101;
    // 110 and 111 are reserved and always evaluate to 0
    localparam logic [MODE_W-1:0] GATE_RSVD_LO = 3'b110;
    localparam logic [MODE_W-1:0] GATE_RSVD_HI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/gate_reduce.sv
// N-input reduction gate selected by a 3-bit mode.
// Purely combinational; reserved modes produce 0.
module gate_reduce
    import gate_pkg::*;
#(
    parameter int unsigned N_INPUTS = 2
) (
    input  logic [MODE_W-1:0]   mode,
    input  logic [N_INPUTS-1:0] a,
    output logic                y
);

    always_comb begin
        y = 1'b0;
        case (mode)
            GATE_AND:  y = &a;
            GATE_OR:   y = |a;
            GATE_XOR:  y = ^a;
            GATE_NAND: y = ~&a;
            GATE_NOR:  y = ~|a;
            GATE_XNOR: y = ~^a;
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_gate_sweep.sv
// Self-sequencing gate characterisation engine: on start it walks every
// input combination, one per clock, and builds the gate's truth table.
module logic_gate_sweep
    import gate_pkg::*;
#(
    parameter int unsigned N_INPUTS = 2,
    parameter int unsigned TT_W     = 2 ** N_INPUTS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          mode,
    output logic                busy,
    output logic                done,
    output logic [N_INPUTS-1:0] in_vec,
    output logic                out_bit,
    output logic [TT_W-1:0]     tt
);

    localparam int unsigned CNT_W = N_INPUTS + 1;

    state_e            state;
    state_e            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [MODE_W-1:0] mode_q;
    logic              last;
    logic              f;

    assign last = (cnt == CNT_W'(TT_W - 1));

    gate_reduce #(
        .N_INPUTS(N_INPUTS)
    ) u_gate_reduce (
        .mode(mode_q),
        .a   (cnt[N_INPUTS-1:0]),
        .y   (f)
    );

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SWEEP;
            ST_SWEEP: if (last)  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            mode_q  <= GATE_AND;
            busy    <= 1'b0;
            done    <= 1'b0;
            in_vec  <= '0;
            out_bit <= 1'b0;
            tt      <= '0;
        end else begin
            busy <= (state_next == ST_SWEEP);
            done <= (state_next == ST_DONE);
            if (state == ST_IDLE && start) begin
                mode_q <= mode;
                tt     <= '0;
                cnt    <= '0;
                in_vec <= '0;
            end else if (state == ST_SWEEP) begin
                out_bit                  <= f;
                tt[cnt[N_INPUTS-1:0]]    <= f;
                cnt                      <= cnt + 1'b1;
                // in_vec parks on the last combination through DONE
                if (!last) begin
                    in_vec <= in_vec + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Bench for logic_gate_sweep: two instances (2 and 3 inputs) checked
// cycle by cycle against a popcount-based truth-table model.
module tb_logic_gate_sweep;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode = 3'b000;

    logic       busy2, done2, out_bit2;
    logic [1:0] in_vec2;
    logic [3:0] tt2;
    logic       busy3, done3, out_bit3;
    logic [2:0] in_vec3;
    logic [7:0] tt3;

    bit          sel3 = 1'b0;
    logic        busy_o, done_o, out_o;
    logic [7:0]  in_o;
    logic [63:0] tt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_gate_sweep #(.N_INPUTS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy2), .done(done2), .in_vec(in_vec2), .out_bit(out_bit2), .tt(tt2)
    );

    logic_gate_sweep #(.N_INPUTS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy3), .done(done3), .in_vec(in_vec3), .out_bit(out_bit3), .tt(tt3)
    );

    always_comb begin
        busy_o = sel3 ? busy3 : busy2;
        done_o = sel3 ? done3 : done2;
        out_o  = sel3 ? out_bit3 : out_bit2;
        in_o   = sel3 ? {5'b0, in_vec3} : {6'b0, in_vec2};
        tt_o   = sel3 ? {56'b0, tt3} : {60'b0, tt2};
    end

    // Gate value from the number of ones in the combination
    function automatic logic ref_f(input int n, input logic [2:0] m, input int k);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += (k >> i) & 1;
        case (m)
            3'd0:    return ones == n;
            3'd1:    return ones > 0;
            3'd2:    return (ones % 2) == 1;
            3'd3:    return ones != n;
            3'd4:    return ones == 0;
            3'd5:    return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Truth table with only combinations below 'upto' filled in
    function automatic logic [63:0] ref_tt(input int n, input logic [2:0] m, input int upto);
        logic [63:0] t = '0;
        for (int k = 0; k < upto; k++) t[k] = ref_f(n, m, k);
        return t;
    endfunction

    // Enters and leaves on a falling edge; leaves in the first IDLE cycle
    task automatic do_sweep(input int n, input logic [2:0] m, input bit disturb);
        int tw = 1 << n;
        int dones = 0;
        int upto, exp_in, ok;
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= tw + 2; c++) begin
            checks++;
            if (busy_o !== (c <= tw)) begin
                errors++;
                $display("FAIL busy n=%0d mode=%0d cyc=%0d got %b want %b", n, m, c, busy_o, (c <= tw));
            end
            checks++;
            if (done_o !== (c == tw + 1)) begin
                errors++;
                $display("FAIL done n=%0d mode=%0d cyc=%0d got %b want %b", n, m, c, done_o, (c == tw + 1));
            end
            if (done_o === 1'b1) dones++;
            if (c <= tw + 1) begin
                exp_in = (c <= tw) ? c - 1 : tw - 1;
                checks++;
                if (in_o !== 8'(exp_in)) begin
                    errors++;
                    $display("FAIL in_vec n=%0d mode=%0d cyc=%0d got %0d want %0d", n, m, c, in_o, exp_in);
                end
            end
            upto = (c - 1 < tw) ? c - 1 : tw;
            checks++;
            if (tt_o !== ref_tt(n, m, upto)) begin
                errors++;
                $display("FAIL tt n=%0d mode=%0d cyc=%0d got %h want %h", n, m, c, tt_o, ref_tt(n, m, upto));
            end
            if (c >= 2) begin
                ok = (c - 2 < tw - 1) ? c - 2 : tw - 1;
                checks++;
                if (out_o !== ref_f(n, m, ok)) begin
                    errors++;
                    $display("FAIL out_bit n=%0d mode=%0d cyc=%0d got %b want %b", n, m, c, out_o, ref_f(n, m, ok));
                end
            end
            if (disturb && c == 2) begin
                start = 1'b1;
                mode  = 3'b001;
            end else if (disturb && c == 3) begin
                start = 1'b0;
            end
            if (c < tw + 2) @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL done_count n=%0d mode=%0d got %0d want 1", n, m, dones);
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy2, done2, in_vec2, out_bit2, tt2} !== 9'b0 ||
            {busy3, done3, in_vec3, out_bit3, tt3} !== 14'b0) begin
            errors++;
            $display("FAIL reset_state got %h/%h want 0", {busy2, done2, in_vec2, out_bit2, tt2},
                     {busy3, done3, in_vec3, out_bit3, tt3});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_and();
        do_sweep(2, 3'b000, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_sweep(2, 3'b010, 1'b0);
        do_sweep(2, 3'b101, 1'b0);
    endtask

    task automatic test_three_inputs();
        idle_cycles(12);
        sel3 = 1'b1;
        do_sweep(3, 3'b100, 1'b0);
        do_sweep(3, 3'b001, 1'b0);
        sel3 = 1'b0;
        idle_cycles(12);
    endtask

    task automatic test_reserved();
        do_sweep(2, 3'b111, 1'b0);
        do_sweep(2, 3'b110, 1'b0);
    endtask

    task automatic test_ignore_start();
        do_sweep(2, 3'b000, 1'b1);
    endtask

    task automatic test_async_reset();
        sel3  = 1'b0;
        start = 1'b1;
        mode  = 3'b101;
        @(negedge clk);
        start = 1'b0;
        idle_cycles(2);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o, out_o} !== 3'b000 || in_o !== 8'd0 || tt_o !== 64'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b out=%b in=%0d tt=%h want all 0",
                     busy_o, done_o, out_o, in_o, tt_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got busy=%b done=%b want 0 0", i, busy_o, done_o);
            end
            @(negedge clk);
        end
        do_sweep(2, 3'b101, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            idle_cycles(10 + int'($urandom_range(0, 3)));
            sel3 = ($urandom_range(0, 1) == 1);
            do_sweep(sel3 ? 3 : 2, 3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
        end
        sel3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_and();
        test_back_to_back();
        test_three_inputs();
        test_reserved();
        test_ignore_start();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_gate_sweep.md
# logic_gate_sweep

Parametrised, self-sequencing successor to the fixed two-input gate bench flow. On `start` it latches a gate mode, steps through all 2^N_INPUTS input combinations, one per clock, and evaluates the selected N-input gate. It also builds the complete truth table in a register and reports completion with a one-cycle `done` pulse. It sits beside the gate models as the shared stimulus/characterisation engine for Task-level benches and for on-chip self-check.

## Interface
- `N_INPUTS`, default 2: gate input count. Legal range 2..6.
- `TT_W`, default 2**N_INPUTS: truth-table width. Derived; do not override.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: sweep request. Sampled only in IDLE.
- `mode`, in, 3: gate select, latched on accepted `start`. 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110/111 reserved.
- `busy`, out, 1: high while sweeping.
- `done`, out, 1: one-cycle pulse when the table is complete.
- `in_vec`, out, N_INPUTS: combination currently applied.
- `out_bit`, out, 1: gate result for the current `in_vec`, registered.
- `tt`, out, TT_W: truth table. Bit k = gate(k).

## Operation
- FSM states:
  - IDLE → SWEEP on `start`=1.
  - SWEEP → DONE when `cnt` = TT_W-1.
  - DONE → IDLE unconditionally.
- Accepted `start` (IDLE):
  - latch `mode` into `mode_q`;
  - clear `tt` to 0;
  - `cnt` ← 0.
- SWEEP, each cycle:
  - `in_vec` = `cnt`;
  - `out_bit` ← f(mode_q, cnt);
  - `tt[cnt]` ← f(mode_q, cnt);
  - `cnt` ← `cnt`+1 (N_INPUTS+1-bit counter, no wrap inside a sweep).
- Gate functions:
  - f is a reduction over all N_INPUTS bits: &, |, ^, and their complements.
  - Reserved modes give f = 0 for every combination. The sweep still runs full length.
- `start` in SWEEP or DONE is ignored. It is not queued.
- `mode` changes after acceptance have no effect until the next accepted `start`.
- `tt` holds its value in IDLE until the next accepted `start`.
- Reset values (asynchronous, immediate):
  - state IDLE;
  - `cnt`=0, `mode_q`=000;
  - `busy`=0, `done`=0, `in_vec`=0, `out_bit`=0, `tt`=0.
- Reset mid-sweep aborts the sweep. All outputs go to reset values, and there is no `done` pulse. A `start` after reset deasserts behaves normally.

## Timing
- Cycle 0: `start`=1 sampled in IDLE.
- Cycle 1: `busy`=1, `in_vec`=0. `out_bit` for `in_vec`=0 is visible in cycle 2 (one-cycle registered latency).
- Cycle k+1, for k = 0..TT_W-1: `in_vec`=k, `busy`=1.
- Cycle TT_W+1, state DONE:
  - `done`=1, `busy`=0;
  - `tt` complete, `out_bit` = f(TT_W-1);
  - `in_vec` holds TT_W-1.
- Cycle TT_W+2: back in IDLE. `done`=0. A new `start` is accepted here at the earliest.
- Start-to-done latency = TT_W+1 cycles. Minimum start-to-start spacing = TT_W+2 cycles.
- `busy` and `done` are never high together.

## Structure
- Shared package `gate_pkg`:
  - mode encodings `GATE_AND`..`GATE_XNOR` and `GATE_RSVD` range;
  - FSM state typedef/localparams `ST_IDLE`, `ST_SWEEP`, `ST_DONE`.
- One combinational sub-module, `gate_reduce`:
  - parameters `N_INPUTS`;
  - inputs `mode`, `a[N_INPUTS-1:0]`;
  - output `y`.
  - It is reused by the gate models.
- Top holds the FSM, counter, mode latch and `tt` register.

## Test plan
- N_INPUTS=2, mode=000 (AND): start → done pulse exactly 5 cycles after start. `tt`=4'b1000, `in_vec` sequence 0,1,2,3.
- N_INPUTS=2, mode=010 (XOR), then mode=101 (XNOR) back-to-back at minimum spacing: `tt`=4'b0110, then 4'b1001. The second sweep clears the first table on acceptance.
- N_INPUTS=3, mode=100 (NOR): `tt`=8'h01. Also mode=001 (OR): `tt`=8'hFE.
- N_INPUTS=2, mode=111 (reserved): full 4-cycle sweep, `tt`=0, `out_bit` stays 0, `done` still pulses.
- Sweep running with mode=000, `start` re-pulsed and `mode` changed to 001 in cycle 2: ignored. Final `tt`=4'b1000 and exactly one `done` pulse.
- `rst` asserted asynchronously mid-cycle in cycle 3 of a sweep: `busy`/`tt`/`in_vec` go to 0 immediately, no `done` follows. A new start after release gives the correct table.
